riscv_ins_encoder: RTL
======================

Name: riscv_ins_encoder

Overview:
Writer side of the controller's instruction decode. It takes instruction fields from the assembler front end over a valid/ready stream and encodes each one into a 32-bit RV32I word. It supports the four formats the controller decodes: load, store, R-type and branch. Each encoded word is written sequentially into instruction memory, starting at word address 0.

Parameters:
ADDR_W, 6, instruction memory word-address width
DEPTH, 64, max words per program (must be <= 2**ADDR_W)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin new program (honoured only in IDLE)
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept bundle
in_last  input  1  bundle is final instruction of program
fmt  input  2  00 load, 01 store, 10 R-type, 11 branch
func3  input  3  funct3 field
func7b5  input  1  funct7 bit 5 (R-type only; 1 = SUB)
rd  input  5  destination reg (load, R-type)
rs1  input  5  source reg 1
rs2  input  5  source reg 2 (store, R-type, branch)
imm  input  13  signed immediate (bit 12 = sign)
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written this program
err_code  output  2  00 none, 01 imm range, 10 branch misaligned, 11 overflow
done  output  1  one-cycle pulse when program closed

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, err_code=00, done=0. State is IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start, clear count, mem_addr index and err_code, then go to RUN.
- RUN: in_ready = (count < DEPTH). start is ignored.
- DONE: done=1 for exactly one cycle, then return to IDLE. in_ready=0.
- Handshake: a bundle is accepted when in_valid && in_ready.
- Write timing: the write happens the cycle after acceptance. mem_we=1 with mem_addr = current index and mem_wdata = encoded word. The index and count increment in that same cycle.
- Throughput is 1 instruction per cycle.
- Encoding:
  - load: {imm[11:0], rs1, func3, rd, 7'b0000011}
  - store: {imm[11:5], rs2, rs1, func3, imm[4:0], 7'b0100011}
  - R-type: {1'b0, func7b5, 5'b0, rs2, rs1, func3, rd, 7'b0110011}
  - branch: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 7'b1100011}
- Range checks:
  - Load/store with imm[12] != imm[11] (does not fit 12-bit signed): err 01, word dropped (no mem_we, no increment).
  - Branch with imm[0]=1: err 10, word dropped.
- err_code is sticky. It holds the first error until the next start.
- Overflow: if in_valid=1 while count==DEPTH in RUN, set err 11 and go to DONE. The pending bundle is not accepted.
- in_last accepted: go to DONE after the final write cycle (or after drop, if the word was invalid).
- in_last accepted together with the bundle that fills DEPTH: go to DONE normally, with no overflow error.
- Reset mid-RUN: return to IDLE immediately. Any pending write is discarded and memory contents are not guaranteed.

Optional Feature:
HALT_APPEND_EN
- Defined: after the in_last instruction is written, and if count < DEPTH, write halt word 0x00000063 (beq x0,x0,0) at the next index, then go to DONE. count includes the halt word. If there is no space, skip the halt word and set err 11.
- Undefined: no halt word is appended; the program ends at the in_last word.

Test Plan:
- lw x5,8(x2): start, fmt=00, rd=5, rs1=2, func3=010, imm=8, in_last=1 -> next cycle mem_we=1, addr=0, wdata=0x00812283; done pulse; count=1.
- sw x6,12(x2) then sub x1,x2,x3 (func7b5=1, func3=000), back-to-back cycles -> wdata 0x00612623 @0, then 0x403100B3 @1; count=2.
- beq x1,x2,-4 (fmt=11, imm=0x1FFC) -> 0xFE208EE3; with HALT_APPEND_EN, next write 0x00000063 @1 and count=2.
- lw with imm=0x0800 -> err_code=01, no mem_we, count unchanged; the following valid R-type still writes at addr 0.
- DEPTH=4, five bundles, in_last on the fifth -> four writes at addr 0..3, in_ready=0 after the fourth, err_code=11, done pulse.
- rst_n low during RUN after 2 writes -> all outputs at reset values; a new start restarts at addr 0 with err_code=00.

Source files
------------

// File: rtl/riscv_ins_encoder.sv
// RV32I instruction encoder: field bundles in, encoded words written to imem.
// Ports: clk, rst_n, start, in_valid/in_ready/in_last, fmt, func3, func7b5,
//   rd, rs1, rs2, imm -> mem_we, mem_addr, mem_wdata, count, err_code, done.
// Optional macro HALT_APPEND_EN appends beq x0,x0,0 after the final word.
module riscv_ins_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [2:0]        func3,
  input  logic              func7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        err_code,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DMAX = (ADDR_W+1)'(DEPTH);
  localparam logic [31:0] HALT = 32'h0000_0063;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx;
  // fin: in_last bundle taken, only its write (and halt) remain
  logic              fin;
  logic              full;
  logic              acc;
  logic              ovf;
  logic [31:0]       word;
  logic [1:0]        bad;
`ifdef HALT_APPEND_EN
  logic              hdone;
`endif

  assign full = (count == DMAX);
  assign acc  = in_valid && in_ready;
  assign done = (state == S_DONE);

  always_comb begin
    word = 32'h0;
    bad  = 2'b00;
    unique case (fmt)
      2'b00: begin
        word = {imm[11:0], rs1, func3, rd, 7'b0000011};
        bad  = (imm[12] != imm[11]) ? 2'b01 : 2'b00;
      end
      2'b01: begin
        word = {imm[11:5], rs2, rs1, func3,
                imm[4:0], 7'b0100011};
        bad  = (imm[12] != imm[11]) ? 2'b01 : 2'b00;
      end
      2'b10: begin
        word = {1'b0, func7b5, 5'b0, rs2, rs1,
                func3, rd, 7'b0110011};
      end
      2'b11: begin
        word = {imm[12], imm[10:5], rs2, rs1, func3,
                imm[4:1], imm[11], 7'b1100011};
        bad  = imm[0] ? 2'b10 : 2'b00;
      end
    endcase
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    ovf      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        in_ready = !fin && !full;
        if (fin) begin
`ifdef HALT_APPEND_EN
          if (hdone || full) state_n = S_DONE;
`else
          state_n = S_DONE;
`endif
        end else if (in_valid && full) begin
          ovf     = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      fin       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      count     <= '0;
      err_code  <= 2'b00;
`ifdef HALT_APPEND_EN
      hdone     <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      mem_we <= 1'b0;
      if (state == S_IDLE && start) begin
        idx      <= '0;
        count    <= '0;
        err_code <= 2'b00;
        fin      <= 1'b0;
`ifdef HALT_APPEND_EN
        hdone    <= 1'b0;
`endif
      end else if (state == S_RUN) begin
        if (acc) begin
          fin <= in_last;
          if (bad == 2'b00) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx;
            mem_wdata <= word;
            idx       <= idx + 1'b1;
            count     <= count + 1'b1;
          end else if (err_code == 2'b00) begin
            err_code <= bad;
          end
        end else if (ovf) begin
          if (err_code == 2'b00) err_code <= 2'b11;
        end
`ifdef HALT_APPEND_EN
        else if (fin && !hdone) begin
          hdone <= 1'b1;
          if (!full) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx;
            mem_wdata <= HALT;
            idx       <= idx + 1'b1;
            count     <= count + 1'b1;
          end else if (err_code == 2'b00) begin
            err_code <= 2'b11;
          end
        end
`endif
      end
    end
  end

endmodule
